// File: rtl/final_cpa_seq.sv
// Sequential final carry-propagate adder: resolves the two reduced partial-product rows
// into the 32-bit product, SEG_W bits per cycle, with an optional OR-only low region.
module final_cpa_seq #(
  parameter int SEG_W      = 8,
  parameter int APPROX_LSB = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_p0,
  input  logic [30:0] row_h,
  input  logic [28:0] row_i,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] product,
  output logic        cout
);

  localparam int NSEG      = (31 + SEG_W - 1) / SEG_W;
  localparam int SEG_CNT_W = (NSEG > 1) ? $clog2(NSEG) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_e;

  state_e                 state_q, state_d;
  logic [SEG_CNT_W-1:0]   seg_q, seg_d;
  logic                   carry_q, carry_d;
  logic                   p0_q, p0_d;
  logic [31:1]            h_q, h_d;
  logic [31:1]            i_q, i_d;
  logic [31:0]            product_q, product_d;
  logic                   cout_q, cout_d;

  logic [31:1]            seg_sum;
  logic                   seg_cout;
  int                     seg_lo;
  int                     seg_hi;

  // Current segment's sum bits are merged into a copy of h_q; h_q accumulates the sum in place.
  always_comb begin
    seg_lo   = 1 + int'(seg_q) * SEG_W;
    seg_hi   = seg_lo + SEG_W - 1;
    if (seg_hi > 31) seg_hi = 31;
    seg_sum  = h_q;
    seg_cout = carry_q;
    // NOTE: blocking assignments here are deliberate; seg_cout ripples bit to bit within one evaluation.
    for (int k = 1; k <= 31; k++) begin
      if (k >= seg_lo && k <= seg_hi) begin
        if (k <= APPROX_LSB) begin
          seg_sum[k] = h_q[k] | i_q[k];
          seg_cout   = 1'b0;
        end else begin
          seg_sum[k] = h_q[k] ^ i_q[k] ^ seg_cout;
          seg_cout   = (h_q[k] & i_q[k]) | (seg_cout & (h_q[k] ^ i_q[k]));
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    seg_d     = seg_q;
    carry_d   = carry_q;
    p0_d      = p0_q;
    h_d       = h_q;
    i_d       = i_q;
    product_d = product_q;
    cout_d    = cout_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          p0_d    = in_p0;
          h_d     = row_h;
          i_d     = {row_i, 2'b00};
          seg_d   = '0;
          carry_d = 1'b0;
          state_d = ADD;
        end
      end
      ADD: begin
        h_d     = seg_sum;
        carry_d = seg_cout;
        if (seg_q == SEG_CNT_W'(NSEG - 1)) begin
          product_d = {seg_sum, p0_q};
          cout_d    = seg_cout;
          seg_d     = '0;
          state_d   = DONE;
        end else begin
          seg_d = seg_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      seg_q     <= '0;
      carry_q   <= 1'b0;
      p0_q      <= 1'b0;
      h_q       <= '0;
      i_q       <= '0;
      product_q <= '0;
      cout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      seg_q     <= seg_d;
      carry_q   <= carry_d;
      p0_q      <= p0_d;
      h_q       <= h_d;
      i_q       <= i_d;
      product_q <= product_d;
      cout_q    <= cout_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign product   = product_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_final_cpa_seq.sv
// Directed bench for final_cpa_seq: five instances (default, approximate, SEG_W sweep)
// sharing clock, reset, row data and out_ready; each has its own in_valid.
module tb_final_cpa_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  in_valid = '0;
  logic [4:0]  in_ready;
  logic [4:0]  out_valid;
  logic [4:0]  cout;
  logic [31:0] product [5];
  logic        in_p0 = 1'b0;
  logic [30:0] row_h = '0;
  logic [28:0] row_i = '0;
  logic        out_ready = 1'b1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // 0: default  1: APPROX_LSB=4  2: SEG_W=1  3: SEG_W=7  4: SEG_W=31
  final_cpa_seq #(.SEG_W(8), .APPROX_LSB(0)) u_def (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_p0(in_p0),
    .row_h(row_h), .row_i(row_i), .out_valid(out_valid[0]), .out_ready(out_ready),
    .product(product[0]), .cout(cout[0]));
  final_cpa_seq #(.SEG_W(8), .APPROX_LSB(4)) u_apx (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_p0(in_p0),
    .row_h(row_h), .row_i(row_i), .out_valid(out_valid[1]), .out_ready(out_ready),
    .product(product[1]), .cout(cout[1]));
  final_cpa_seq #(.SEG_W(1), .APPROX_LSB(0)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_p0(in_p0),
    .row_h(row_h), .row_i(row_i), .out_valid(out_valid[2]), .out_ready(out_ready),
    .product(product[2]), .cout(cout[2]));
  final_cpa_seq #(.SEG_W(7), .APPROX_LSB(0)) u_s7 (
    .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]), .in_p0(in_p0),
    .row_h(row_h), .row_i(row_i), .out_valid(out_valid[3]), .out_ready(out_ready),
    .product(product[3]), .cout(cout[3]));
  final_cpa_seq #(.SEG_W(31), .APPROX_LSB(0)) u_s31 (
    .clk(clk), .rst(rst), .in_valid(in_valid[4]), .in_ready(in_ready[4]), .in_p0(in_p0),
    .row_h(row_h), .row_i(row_i), .out_valid(out_valid[4]), .out_ready(out_ready),
    .product(product[4]), .cout(cout[4]));

  // Runs one job on instance d; lat = edges from acceptance to the output handshake edge.
  task automatic do_job(input int d, input logic [31:0] h, input logic [31:0] i, input logic p0,
                        output int lat, output logic [31:0] prod, output logic co, output bit to);
    int n;
    to = 1'b0; lat = 0; prod = '0; co = 1'b0;
    row_h = h[31:1]; row_i = i[31:3]; in_p0 = p0; in_valid[d] = 1'b1;
    n = 0;
    while (!in_ready[d] && n < 200) begin @(posedge clk); #1; n++; end
    if (!in_ready[d]) begin in_valid[d] = 1'b0; to = 1'b1; return; end
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    n = 0;
    while (!out_valid[d] && n < 100) begin @(posedge clk); #1; n++; end
    if (!out_valid[d]) begin to = 1'b1; return; end
    lat = n + 1; prod = product[d]; co = cout[d];
    if (out_ready) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    for (int d = 0; d < 5; d++) begin
      tests++;
      if (in_ready[d] !== 1'b0 || out_valid[d] !== 1'b0 || product[d] !== 32'h0 || cout[d] !== 1'b0) begin
        fails++;
        $display("FAIL reset_state[%0d]: in_ready=%b out_valid=%b product=%h cout=%b, expected 0 0 00000000 0",
                 d, in_ready[d], out_valid[d], product[d], cout[d]);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (in_ready !== 5'b11111 || out_valid !== 5'b00000) begin
      fails++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, expected 11111 00000", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    int lat; logic [31:0] prod; logic co; bit to;
    do_job(0, 32'h0000_0002, 32'h0000_0008, 1'b1, lat, prod, co, to);
    tests++;
    if (to || lat !== 5) begin fails++; $display("FAIL basic_latency: got %0d expected 5 (timeout=%0b)", lat, to); end
    tests++;
    if (prod !== 32'h0000_000B || co !== 1'b0) begin
      fails++; $display("FAIL basic_result: got %h/%b expected 0000000b/0", prod, co);
    end
  endtask

  task automatic test_carry_chain();
    int lat; logic [31:0] prod; logic co; bit to;
    do_job(0, 32'hFFFF_FFFE, 32'h0000_0008, 1'b0, lat, prod, co, to);
    tests++;
    if (to || prod !== 32'h0000_0006 || co !== 1'b1) begin
      fails++; $display("FAIL carry_chain: got %h/%b expected 00000006/1 (timeout=%0b)", prod, co, to);
    end
    do_job(0, 32'hAAAA_AAAA, 32'h5555_5550, 1'b1, lat, prod, co, to);
    tests++;
    if (to || prod !== 32'hFFFF_FFFB || co !== 1'b0) begin
      fails++; $display("FAIL alt_pattern: got %h/%b expected fffffffb/0 (timeout=%0b)", prod, co, to);
    end
  endtask

  task automatic test_approx();
    int lat; logic [31:0] prod; logic co; bit to;
    do_job(1, 32'h0000_001E, 32'h0000_0018, 1'b0, lat, prod, co, to);
    tests++;
    if (to || prod !== 32'h0000_001E || co !== 1'b0) begin
      fails++; $display("FAIL approx_region: got %h/%b expected 0000001e/0 (timeout=%0b)", prod, co, to);
    end
    do_job(0, 32'h0000_001E, 32'h0000_0018, 1'b0, lat, prod, co, to);
    tests++;
    if (to || prod !== 32'h0000_0036 || co !== 1'b0) begin
      fails++; $display("FAIL exact_same_rows: got %h/%b expected 00000036/0 (timeout=%0b)", prod, co, to);
    end
    // Carry out of bit 4 must not enter bit 5 in the approximate unit.
    do_job(1, 32'hFFFF_FFFE, 32'h0000_0008, 1'b1, lat, prod, co, to);
    tests++;
    if (to || prod !== 32'hFFFF_FFFF || co !== 1'b0) begin
      fails++; $display("FAIL approx_no_carry: got %h/%b expected ffffffff/0 (timeout=%0b)", prod, co, to);
    end
  endtask

  task automatic test_backpressure();
    int n;
    out_ready = 1'b0;
    row_h = 31'h8; row_i = 29'h4; in_p0 = 1'b1;     // h=0x10, i=0x20 -> 0x31
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    row_h = 31'h80; row_i = 29'h1; in_p0 = 1'b0;    // h=0x100, i=0x8 -> 0x108, offered early
    n = 0;
    while (!out_valid[0] && n < 100) begin @(posedge clk); #1; n++; end
    for (int c = 0; c < 3; c++) begin
      tests++;
      if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || product[0] !== 32'h31 || cout[0] !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b product=%h cout=%b, expected 1 0 00000031 0",
                 c, out_valid[0], in_ready[0], product[0], cout[0]);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
      fails++; $display("FAIL bp_after_handshake: in_ready=%b out_valid=%b expected 1 0", in_ready[0], out_valid[0]);
    end
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    tests++;
    if (in_ready[0] !== 1'b0) begin
      fails++; $display("FAIL bp_second_accept: in_ready=%b expected 0", in_ready[0]);
    end
    n = 0;
    while (!out_valid[0] && n < 100) begin @(posedge clk); #1; n++; end
    tests++;
    if (out_valid[0] !== 1'b1 || product[0] !== 32'h108 || cout[0] !== 1'b0) begin
      fails++; $display("FAIL bp_second_job: out_valid=%b product=%h cout=%b expected 1 00000108 0",
                        out_valid[0], product[0], cout[0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int n; logic r;
    row_h = 31'h1; row_i = 29'h1; in_p0 = 1'b1;
    in_valid[0] = 1'b1;
    n = 0;
    while (!in_ready[0] && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    n = 0;
    r = 1'b0;
    while (!r && n < 50) begin
      r = in_ready[0];
      @(posedge clk); #1;
      n++;
    end
    in_valid[0] = 1'b0;
    tests++;
    if (n !== 6) begin fails++; $display("FAIL back_to_back_ii: got %0d expected 6", n); end
    n = 0;
    while (!out_valid[0] && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_add();
    int lat; logic [31:0] prod; logic co; bit to;
    row_h = 31'h7FFF_FFFF; row_i = 29'h1; in_p0 = 1'b1;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    tests++;
    if (out_valid[0] !== 1'b0 || product[0] !== 32'h0 || cout[0] !== 1'b0 || in_ready[0] !== 1'b0) begin
      fails++; $display("FAIL mid_add_reset: out_valid=%b product=%h cout=%b in_ready=%b expected 0 00000000 0 0",
                        out_valid[0], product[0], cout[0], in_ready[0]);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b0) begin
      fails++; $display("FAIL mid_add_hold: out_valid=%b in_ready=%b expected 0 0", out_valid[0], in_ready[0]);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    do_job(0, 32'h0000_0002, 32'h0000_0008, 1'b1, lat, prod, co, to);
    tests++;
    if (to || lat !== 5 || prod !== 32'h0000_000B || co !== 1'b0) begin
      fails++; $display("FAIL after_reset_job: lat=%0d product=%h cout=%b expected 5 0000000b 0 (timeout=%0b)",
                        lat, prod, co, to);
    end
  endtask

  task automatic test_sweep();
    int lat; logic [31:0] prod; logic co; bit to;
    logic [31:0] h, i; logic p0; logic [32:0] ref_sum;
    int exp_lat [5] = '{5, 5, 32, 6, 2};
    for (int d = 2; d < 5; d++) begin
      for (int v = 0; v < 4; v++) begin
        case (v)
          0: begin h = 32'hFFFF_FFFE; i = 32'hFFFF_FFF8; p0 = 1'b1; end
          1: begin h = 32'h8000_0002; i = 32'h8000_0008; p0 = 1'b0; end
          default: begin h = $urandom; i = $urandom; p0 = 1'($urandom_range(1)); end
        endcase
        ref_sum = {1'b0, h[31:1], 1'b0} + {1'b0, i[31:3], 3'b000} + {32'b0, p0};
        do_job(d, h, i, p0, lat, prod, co, to);
        tests++;
        if (to || lat !== exp_lat[d] || prod !== ref_sum[31:0] || co !== ref_sum[32]) begin
          fails++;
          $display("FAIL sweep[%0d.%0d]: lat=%0d product=%h cout=%b expected %0d %h %b (timeout=%0b)",
                   d, v, lat, prod, co, exp_lat[d], ref_sum[31:0], ref_sum[32], to);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_chain();
    test_approx();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_add();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
